nibble_serial_adder: RTL

//  Multi-cycle WIDTH-bit adder front end. It accepts one operand pair over a valid/ready handshake and steps it

---
 rtl/nibble_serial_adder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder front end. Accepts one operand pair over a
//   valid/ready handshake, then steps it through an external 4-bit ripple
//   carry adder one nibble per clock, LSB nibble first. The carry is held in
//   a register between nibbles, the nibble sums are collected into a
//   WIDTH-bit result, and the result is returned over a valid/ready handshake.
//
// Parameters
//   WIDTH      operand/result width, multiple of 4 and >= 8
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   operand pair and in_cin valid
//   in_ready   block can accept an operand pair (IDLE only)
//   in_a/in_b  operands, sampled only at the accept edge
//   in_cin     carry into nibble 0
//   add_a/b    nibble operands to the 4-bit adder (0 outside RUN)
//   add_cin    carry to the 4-bit adder (0 outside RUN)
//   add_sum    nibble sum from the 4-bit adder (combinational)
//   add_cout   carry out from the 4-bit adder (combinational)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   out_sum    result sum, stable while out_valid=1
//   out_cout   carry out of the MSB nibble
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDXW    = $clog2(NIBBLES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              carry_reg;
    logic [IDXW-1:0]   idx;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= in_a;
                        b_reg     <= in_b;
                        carry_reg <= in_cin;
                        idx       <= '0;
                    end
                end
                RUN: begin
                    sum_reg[4*idx +: 4] <= add_sum;
                    carry_reg           <= add_cout;
                    // idx stops at the last nibble so it never wraps
                    if (idx != LAST_IDX) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sum   = '0;
        out_cout  = 1'b0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // adder drive is forced to 0 while reset is held
                if (!rst) begin
                    add_a   = a_reg[4*idx +: 4];
                    add_b   = b_reg[4*idx +: 4];
                    add_cin = carry_reg;
                end
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_sum   = sum_reg;
                out_cout  = carry_reg;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
